tmds_dec: RTL and testbench

Receive-side TMDS channel decoder for the HDMI path: accepts one 10-bit parallel symbol per pixel clock from the deserializer and recovers the 8-bit pixel component, the blanking flag and the 2-bit control data. It also runs a word-alignment state machine that pulses `bitslip` back to the deserializer until control tokens are received consistently, and then reports `locked`. One instance is used per colour channel, ahead of the capture/video-input logic.

---
 rtl/tmds_pkg.sv | 19 +
 rtl/tmds_dec_if.sv | 13 +
 rtl/tmds_align.sv | 117 +++++++++++
 rtl/tmds_dec.sv | 74 +++++++
 tb/tb_tmds_dec.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token table indexed by c, and the
// receive word-alignment state encoding.
package tmds_pkg;

    localparam logic [9:0] CTRL_TOKEN [4] = '{
        10'b1101010100,
        10'b0010101011,
        10'b0101010100,
        10'b1010101011
    };

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_HOLDOFF,
        ST_VERIFY,
        ST_LOCKED
    } align_state_t;

endpackage

// File: rtl/tmds_dec_if.sv
// Symbol input and decoded outputs of one TMDS receive channel.
// master = deserializer/capture side, slave = decoder.
interface tmds_dec_if;
    logic [9:0] q;
    logic [7:0] data;
    logic       blk;
    logic [1:0] c;
    logic       locked;
    logic       bitslip;

    modport master (output q, input data, blk, c, locked, bitslip);
    modport slave  (input q, output data, blk, c, locked, bitslip);
endinterface

// File: rtl/tmds_align.sv
// Word-alignment FSM: slips the deserializer until a steady run of control
// tokens is seen, then holds lock until tokens disappear for too long.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_SEARCH  | no alignment; count idle cycles, bitslip on timeout
// ST_HOLDOFF | deserializer settling after a bitslip; symbols ignored
// ST_VERIFY  | counting consecutive tokens; any data symbol -> bitslip
// ST_LOCKED  | aligned; drop lock after a long run without tokens
module tmds_align
    import tmds_pkg::*;
#(
    parameter int LOCK_TOKENS  = 8,
    parameter int SLIP_TIMEOUT = 2048,
    parameter int SLIP_HOLDOFF = 4,
    parameter int LOSS_TIMEOUT = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic tok,
    output logic locked,
    output logic bitslip
);
    localparam int IDLE_MAX = (SLIP_TIMEOUT > LOSS_TIMEOUT) ? SLIP_TIMEOUT : LOSS_TIMEOUT;
    localparam int IDLE_W   = $clog2(IDLE_MAX + 1);
    localparam int RUN_W    = $clog2(LOCK_TOKENS + 1);
    localparam int HOLD_W   = $clog2(SLIP_HOLDOFF + 1);

    localparam logic [IDLE_W-1:0] SLIP_TC = IDLE_W'(SLIP_TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] LOSS_TC = IDLE_W'(LOSS_TIMEOUT - 1);
    localparam logic [RUN_W-1:0]  RUN_TC  = RUN_W'(LOCK_TOKENS - 1);
    localparam logic [HOLD_W-1:0] HOLD_TC = HOLD_W'(SLIP_HOLDOFF - 1);

    align_state_t      state, state_nxt;
    logic [IDLE_W-1:0] idle_cnt, idle_nxt;
    logic [RUN_W-1:0]  run_cnt, run_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              slip_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_SEARCH;
            idle_cnt <= '0;
            run_cnt  <= '0;
            hold_cnt <= '0;
            bitslip  <= 1'b0;
        end else begin
            state    <= state_nxt;
            idle_cnt <= idle_nxt;
            run_cnt  <= run_nxt;
            hold_cnt <= hold_nxt;
            bitslip  <= slip_nxt;
        end
    end

    // Every counter is cleared on its own terminal count, so none saturates.
    always_comb begin
        state_nxt = state;
        idle_nxt  = idle_cnt;
        run_nxt   = run_cnt;
        hold_nxt  = hold_cnt;
        slip_nxt  = 1'b0;
        unique case (state)
            ST_SEARCH: begin
                if (tok) begin
                    state_nxt = ST_VERIFY;
                    run_nxt   = RUN_W'(1);
                    idle_nxt  = '0;
                end else if (idle_cnt == SLIP_TC) begin
                    state_nxt = ST_HOLDOFF;
                    slip_nxt  = 1'b1;
                    idle_nxt  = '0;
                    hold_nxt  = '0;
                end else begin
                    idle_nxt = idle_cnt + IDLE_W'(1);
                end
            end
            ST_HOLDOFF: begin
                if (hold_cnt == HOLD_TC) begin
                    state_nxt = ST_SEARCH;
                    hold_nxt  = '0;
                    idle_nxt  = '0;
                end else begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            ST_VERIFY: begin
                if (!tok) begin
                    state_nxt = ST_HOLDOFF;
                    slip_nxt  = 1'b1;
                    run_nxt   = '0;
                    hold_nxt  = '0;
                end else if (run_cnt == RUN_TC) begin
                    state_nxt = ST_LOCKED;
                    run_nxt   = '0;
                    idle_nxt  = '0;
                end else begin
                    run_nxt = run_cnt + RUN_W'(1);
                end
            end
            ST_LOCKED: begin
                if (tok) begin
                    idle_nxt = '0;
                end else if (idle_cnt == LOSS_TC) begin
                    state_nxt = ST_SEARCH;
                    idle_nxt  = '0;
                end else begin
                    idle_nxt = idle_cnt + IDLE_W'(1);
                end
            end
            default: state_nxt = ST_SEARCH;
        endcase
    end

    assign locked = (state == ST_LOCKED);

endmodule

// File: rtl/tmds_dec.sv
// TMDS receive channel: two-stage pipeline (symbol register, decoded
// output register) with the alignment FSM watching the stage-1 symbol.
module tmds_dec
    import tmds_pkg::*;
#(
    parameter int LOCK_TOKENS  = 8,
    parameter int SLIP_TIMEOUT = 2048,
    parameter int SLIP_HOLDOFF = 4,
    parameter int LOSS_TIMEOUT = 4096
) (
    input logic       clk,
    input logic       reset,
    tmds_dec_if.slave bus
);
    logic [9:0] q_s1;
    logic       tok;
    logic [1:0] tok_c;
    logic [7:0] t;
    logic [7:0] dec;
    logic       locked;
    logic       bitslip;

    always_comb begin
        tok   = 1'b0;
        tok_c = 2'b00;
        for (int i = 0; i < 4; i++) begin
            if (q_s1 == CTRL_TOKEN[i]) begin
                tok   = 1'b1;
                tok_c = 2'(i);
            end
        end
    end

    // Undo the optional inversion, then the XOR/XNOR transition chain.
    always_comb begin
        t      = q_s1[9] ? ~q_s1[7:0] : q_s1[7:0];
        dec    = '0;
        dec[0] = t[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = q_s1[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_s1     <= '0;
            bus.data <= '0;
            bus.blk  <= 1'b0;
            bus.c    <= 2'b00;
        end else begin
            q_s1     <= bus.q;
            bus.blk  <= tok;
            bus.c    <= tok ? tok_c : 2'b00;
            bus.data <= tok ? 8'h00 : dec;
        end
    end

    tmds_align #(
        .LOCK_TOKENS (LOCK_TOKENS),
        .SLIP_TIMEOUT(SLIP_TIMEOUT),
        .SLIP_HOLDOFF(SLIP_HOLDOFF),
        .LOSS_TIMEOUT(LOSS_TIMEOUT)
    ) u_align (
        .clk    (clk),
        .reset  (reset),
        .tok    (tok),
        .locked (locked),
        .bitslip(bitslip)
    );

    assign bus.locked  = locked;
    assign bus.bitslip = bitslip;

endmodule

// File: tb/tb_tmds_dec.sv
// Bench for tmds_dec: reference TMDS encoder feeds the decoder, a two-deep
// expectation pipeline checks decode, and alignment events are timed.
module tb_tmds_dec;
    localparam int LOCK_TOKENS  = 8;
    localparam int SLIP_TIMEOUT = 64;
    localparam int SLIP_HOLDOFF = 4;
    localparam int LOSS_TIMEOUT = 128;

    logic clk = 1'b0;
    logic reset = 1'b1;
    tmds_dec_if bus ();

    tmds_dec #(
        .LOCK_TOKENS (LOCK_TOKENS),
        .SLIP_TIMEOUT(SLIP_TIMEOUT),
        .SLIP_HOLDOFF(SLIP_HOLDOFF),
        .LOSS_TIMEOUT(LOSS_TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         known;
        logic [7:0] d;
        logic       b;
        logic [1:0] c;
    } exp_t;

    logic [9:0] tok_tab [4];
    int   n_assert = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   slips[$];
    logic prev_slip = 1'b0;
    int   enc_disp = 0;
    exp_t pend0, pend1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (pend1.known) begin
            chk("data", 32'(bus.data), 32'(pend1.d));
            chk("blk", 32'(bus.blk), 32'(pend1.b));
            chk("c", 32'(bus.c), 32'(pend1.c));
        end
        pend1 = pend0;
        pend0.known = 1'b0;
        if (bus.bitslip === 1'b1) begin
            slips.push_back(cyc);
            chk("bitslip_not_consecutive", 32'(prev_slip), 32'd0);
        end
        prev_slip = bus.bitslip;
    endtask

    task automatic drive(input logic [9:0] sym, input bit known, input logic [7:0] d,
                         input logic b, input logic [1:0] c);
        bus.q = sym;
        pend0.known = known;
        pend0.d = d;
        pend0.b = b;
        pend0.c = c;
    endtask

    // Standard DVI/HDMI 8b/10b data encoder with running disparity.
    function automatic logic [9:0] encode(input logic [7:0] d);
        int         n1;
        bit         use_xnor;
        logic [8:0] qm;
        int         ones, zeros;
        logic [9:0] s;
        n1 = $countones(d);
        use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++)
            qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = ~use_xnor;
        ones = $countones(qm[7:0]);
        zeros = 8 - ones;
        if (enc_disp == 0 || ones == zeros) begin
            s = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            enc_disp += qm[8] ? (ones - zeros) : (zeros - ones);
        end else if ((enc_disp > 0 && ones > zeros) || (enc_disp < 0 && zeros > ones)) begin
            s = {1'b1, qm[8], ~qm[7:0]};
            enc_disp += (qm[8] ? 2 : 0) + zeros - ones;
        end else begin
            s = {1'b0, qm[8], qm[7:0]};
            enc_disp += ones - zeros - (qm[8] ? 0 : 2);
        end
        return s;
    endfunction

    // Word seen by a receiver whose boundary is r bits late in a repeating stream of w.
    function automatic logic [9:0] rotw(input logic [9:0] w, input int r);
        logic [9:0] o;
        for (int k = 0; k < 10; k++) o[k] = w[(k + r) % 10];
        return o;
    endfunction

    task automatic send_tok(input int ci);
        drive(tok_tab[ci], 1'b1, 8'h00, 1'b1, 2'(ci));
    endtask

    task automatic send_byte(input logic [7:0] b);
        drive(encode(b), 1'b1, b, 1'b0, 2'b00);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        pend0.known = 1'b0;
        pend1.known = 1'b0;
        bus.q = 10'($urandom);
        repeat (n) tick();
        chk("rst_data", 32'(bus.data), 32'd0);
        chk("rst_blk", 32'(bus.blk), 32'd0);
        chk("rst_c", 32'(bus.c), 32'd0);
        chk("rst_locked", 32'(bus.locked), 32'd0);
        chk("rst_bitslip", 32'(bus.bitslip), 32'd0);
        reset = 1'b0;
        slips.delete();
        prev_slip = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int   base;
        int   lock_t;
        int   r;
        int   seen_lock;
        logic [7:0] perm [256];

        tok_tab[0] = 10'b1101010100;
        tok_tab[1] = 10'b0010101011;
        tok_tab[2] = 10'b0101010100;
        tok_tab[3] = 10'b1010101011;
        pend0.known = 1'b0;
        pend1.known = 1'b0;
        bus.q = '0;

        // Reset for 3 cycles, idle q=0: first bitslip SLIP_TIMEOUT cycles after release.
        do_reset(3);
        base = cyc;
        while (slips.size() == 0 && cyc - base < SLIP_TIMEOUT + 10) begin
            drive(10'h000, 1'b0, 8'h00, 1'b0, 2'b00);
            tick();
            if (cyc - base == SLIP_TIMEOUT - 1) chk("idle_no_lock", 32'(bus.locked), 32'd0);
        end
        chk("first_slip_seen", 32'(slips.size()), 32'd1);
        if (slips.size() > 0) chk("first_slip_delay", 32'(slips[0] - base), 32'(SLIP_TIMEOUT));

        // 12 blanking tokens, 0x3FF, then random data until lock is lost.
        do_reset(1);
        base = cyc;
        for (int k = 1; k <= 13 + LOSS_TIMEOUT; k++) begin
            if (k <= 12) send_tok(0);
            else if (k == 13) drive(10'h3FF, 1'b1, 8'h00, 1'b0, 2'b00);
            else send_byte(8'($urandom));
            tick();
            if (k == LOCK_TOKENS) chk("lock_before_nth", 32'(bus.locked), 32'd0);
            if (k == LOCK_TOKENS + 1) chk("lock_rise", 32'(bus.locked), 32'd1);
            if (k == 12 + LOSS_TIMEOUT) chk("lock_hold", 32'(bus.locked), 32'd1);
            if (k == 13 + LOSS_TIMEOUT) chk("lock_drop", 32'(bus.locked), 32'd0);
        end
        chk("loss_no_slip", 32'(slips.size()), 32'd0);

        // All 256 bytes, shuffled, from an encoder with arbitrary starting disparity.
        do_reset(1);
        enc_disp = 2 * int'($urandom_range(0, 8)) - 8;
        for (int i = 0; i < 256; i++) perm[i] = 8'(i);
        for (int i = 255; i > 0; i--) begin
            int j;
            logic [7:0] tmp;
            j = int'($urandom_range(0, i));
            tmp = perm[i];
            perm[i] = perm[j];
            perm[j] = tmp;
        end
        for (int i = 0; i < 256; i++) begin
            send_byte(perm[i]);
            tick();
        end
        repeat (2) tick();

        // Token stream arriving 3 bits late: each bitslip moves the boundary by one.
        do_reset(1);
        base = cyc;
        r = 3;
        lock_t = -1;
        while (cyc - base < 4 * (SLIP_TIMEOUT + SLIP_HOLDOFF) + 40 &&
               !(lock_t >= 0 && cyc > lock_t + 20)) begin
            drive(rotw(tok_tab[0], r), (r == 0), 8'h00, 1'b1, 2'b00);
            tick();
            if (bus.bitslip === 1'b1) r = (r + 9) % 10;
            if (bus.locked === 1'b1 && lock_t < 0) lock_t = cyc;
        end
        chk("rot_slip_count", 32'(slips.size()), 32'd3);
        chk("rot_locked", 32'(bus.locked), 32'd1);
        if (slips.size() >= 3) begin
            chk("rot_slip0_time", 32'(slips[0] - base), 32'(SLIP_TIMEOUT));
            chk("rot_slip1_gap", 32'(slips[1] - slips[0]), 32'(SLIP_TIMEOUT + SLIP_HOLDOFF));
            chk("rot_slip2_gap", 32'(slips[2] - slips[1]), 32'(SLIP_TIMEOUT + SLIP_HOLDOFF));
            chk("rot_lock_time", 32'(lock_t - slips[2]), 32'(SLIP_HOLDOFF + LOCK_TOKENS));
        end

        // VERIFY broken after 5 tokens (all four token codes) by a data symbol.
        do_reset(1);
        base = cyc;
        seen_lock = 0;
        for (int k = 1; k <= 25; k++) begin
            if (k <= 5) send_tok((k - 1) % 4);
            else send_byte(8'($urandom));
            tick();
            if (bus.locked === 1'b1) seen_lock = 1;
        end
        chk("verify_slip_count", 32'(slips.size()), 32'd1);
        if (slips.size() > 0) chk("verify_slip_time", 32'(slips[0] - base), 32'd7);
        chk("verify_never_locked", 32'(seen_lock), 32'd0);

        // Reset during VERIFY: the token run must restart from zero.
        do_reset(1);
        for (int k = 1; k <= 3; k++) begin
            send_tok(2);
            tick();
        end
        do_reset(1);
        for (int k = 1; k <= LOCK_TOKENS + 1; k++) begin
            send_tok(3);
            tick();
            if (k == LOCK_TOKENS) chk("rst_verify_no_early_lock", 32'(bus.locked), 32'd0);
            if (k == LOCK_TOKENS + 1) chk("rst_verify_lock", 32'(bus.locked), 32'd1);
        end
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
